// File: rtl/g9_stage_sequencer.sv
// g9_stage_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB stepper for the G9 core.
// Issues one-cycle enables for IR load, PC update, RF write and DMem access,
// honouring block-RAM read latency. Supports free-run, single-step and HALT.
module g9_stage_sequencer #(
  parameter int IMEM_LATENCY = 1,
  parameter int DMEM_LATENCY = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step_mode,
  input  logic                 step,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 reg_write,
  input  logic                 halt,
  output logic                 ir_load,
  output logic                 pc_en,
  output logic                 rf_we,
  output logic                 dmem_we,
  output logic                 dmem_re,
  output logic                 busy,
  output logic                 halted,
  output logic [2:0]           stage,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [2:0] IM_LAST = 3'(IMEM_LATENCY - 1);
  localparam logic [2:0] DM_LAST = 3'(DMEM_LATENCY - 1);

  state_t               r_state;
  logic [2:0]           r_wait;
  logic                 r_mr, r_mw, r_rw;
  logic [CNT_WIDTH-1:0] r_retired;

  logic w_imem_last, w_dmem_last, w_retire;

  assign w_imem_last = (r_wait == IM_LAST);
  assign w_dmem_last = (r_wait == DM_LAST);

  // Strobes come only from registered state, wait counter and latched flags.
  assign ir_load = (r_state == S_FETCH) && w_imem_last;
  assign w_retire = ((r_state == S_EXEC) && !(r_mr || r_mw || r_rw)) ||
                    ((r_state == S_MEM) && w_dmem_last && !r_mr) ||
                    (r_state == S_WB);
  assign pc_en   = w_retire;
  assign rf_we   = (r_state == S_WB);
  assign dmem_re = (r_state == S_MEM) && r_mr;
  // A load+store combination is treated as a load: no write.
  assign dmem_we = (r_state == S_MEM) && r_mw && !r_mr && (r_wait == 3'd0);
  assign busy    = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted  = (r_state == S_HALT);
  assign stage   = r_state;
  assign retired = r_retired;

  // Stage FSM, latency wait counter, decode-time flag latch and retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_wait    <= 3'd0;
      r_mr      <= 1'b0;
      r_mw      <= 1'b0;
      r_rw      <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run && (!step_mode || step)) begin
            r_state <= S_FETCH;
            r_wait  <= 3'd0;
          end
        end
        S_FETCH: begin
          if (w_imem_last) begin
            r_state <= S_DECODE;
            r_wait  <= 3'd0;
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end
        S_DECODE: begin
          r_mr    <= mem_read;
          r_mw    <= mem_write;
          r_rw    <= reg_write;
          r_state <= halt ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          if (r_mr || r_mw) begin
            r_state <= S_MEM;
            r_wait  <= 3'd0;
          end else if (r_rw) begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (w_dmem_last) begin
            r_wait <= 3'd0;
            if (r_mr) r_state <= S_WB;
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end
        S_WB:   ;
        S_HALT: ;
        default: begin
          r_state <= S_IDLE;
          r_wait  <= 3'd0;
        end
      endcase
      // Retire overrides the per-state next state: chain or fall back to IDLE.
      if (w_retire) begin
        r_retired <= r_retired + CNT_WIDTH'(1);
        r_state   <= (run && !step_mode) ? S_FETCH : S_IDLE;
        r_wait    <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_g9_stage_sequencer.sv
// Scoreboard bench for g9_stage_sequencer: an instruction-level model expands
// each issued instruction into its expected per-cycle outputs; a monitor pops
// and compares one entry per cycle.
module tb_g9_stage_sequencer;
  localparam int L  = 2;
  localparam int D  = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0, step_mode = 1'b0, step = 1'b0;
  logic mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0, halt = 1'b0;
  logic ir_load, pc_en, rf_we, dmem_we, dmem_re, busy, halted;
  logic [2:0]    stage;
  logic [CW-1:0] retired;

  g9_stage_sequencer #(.IMEM_LATENCY(L), .DMEM_LATENCY(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .step_mode(step_mode), .step(step),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .halt(halt),
    .ir_load(ir_load), .pc_en(pc_en), .rf_we(rf_we), .dmem_we(dmem_we),
    .dmem_re(dmem_re), .busy(busy), .halted(halted), .stage(stage), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] stg;
    logic ir, pc, rf, we, re;
  } cyc_t;

  typedef struct packed {
    cyc_t          c;
    logic [CW-1:0] ret;
  } sb_t;

  cyc_t pend[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  // Model state
  logic [CW-1:0] cnt = '0;
  bit halted_m = 0;
  bit cur_mr, cur_mw, cur_rw, cur_hl;
  int force_kind = -1;
  bit allow_halt = 0;

  function automatic cyc_t mk(input logic [2:0] s, input logic ir, pc, rf, we, re);
    cyc_t c;
    c.stg = s; c.ir = ir; c.pc = pc; c.rf = rf; c.we = we; c.re = re;
    return c;
  endfunction

  // Expand one instruction into its cycle-by-cycle expected outputs.
  task automatic build();
    int k;
    k = (force_kind >= 0) ? force_kind : $urandom_range(0, allow_halt ? 7 : 6);
    cur_mr = 0; cur_mw = 0; cur_rw = 0; cur_hl = 0;
    case (k)
      0: cur_rw = 1;
      1: begin cur_mr = 1; cur_rw = 1; end
      2: cur_mr = 1;
      3: cur_mw = 1;
      4: begin cur_mw = 1; cur_rw = 1; end
      5: begin cur_mr = 1; cur_mw = 1; cur_rw = 1'($urandom_range(0, 1)); end
      6: ;
      default: begin
        cur_hl = 1; cur_mr = 1'($urandom_range(0, 1));
        cur_mw = 1'($urandom_range(0, 1)); cur_rw = 1'($urandom_range(0, 1));
      end
    endcase
    for (int i = 0; i < L; i++) pend.push_back(mk(3'd1, i == L - 1, 0, 0, 0, 0));
    pend.push_back(mk(3'd2, 0, 0, 0, 0, 0));
    if (cur_hl) return;
    pend.push_back(mk(3'd3, 0, !(cur_mr || cur_mw || cur_rw), 0, 0, 0));
    if (cur_mr || cur_mw)
      for (int i = 0; i < D; i++)
        pend.push_back(mk(3'd4, 0, (i == D - 1) && !cur_mr, 0,
                          cur_mw && !cur_mr && (i == 0), cur_mr));
    if (cur_mr || (!cur_mw && cur_rw)) pend.push_back(mk(3'd5, 0, 1, 1, 0, 0));
  endtask

  // One clock of stimulus plus the matching expected entry.
  task automatic tick(input bit run_v, input bit sm_v, input bit step_v);
    cyc_t c;
    @(posedge clk); #1;
    run = run_v; step_mode = sm_v; step = step_v;
    if (pend.size() > 0 && pend[0].stg == 3'd2) begin
      mem_read = cur_mr; mem_write = cur_mw; reg_write = cur_rw; halt = cur_hl;
    end else begin
      mem_read = 1'($urandom_range(0, 1)); mem_write = 1'($urandom_range(0, 1));
      reg_write = 1'($urandom_range(0, 1)); halt = 1'($urandom_range(0, 1));
    end
    if (pend.size() > 0) c = pend.pop_front();
    else c = halted_m ? mk(3'd6, 0, 0, 0, 0, 0) : mk(3'd0, 0, 0, 0, 0, 0);
    sb.push_back('{c: c, ret: cnt});
    if (c.stg == 3'd2 && cur_hl) halted_m = 1;
    if (c.stg == 3'd0 && run_v && (!sm_v || step_v)) build();
    if (c.pc) begin
      cnt = cnt + 1'b1;
      if (run_v && !sm_v) build();
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete(); cnt = '0; halted_m = 0; force_kind = -1;
    run = 0; step = 0;
  endtask

  // Release reset mid-cycle with run low so the first post-reset edge stays IDLE.
  task automatic release_reset();
    @(posedge clk); #1;
    run = 0; step = 0;
    reset = 1'b1;
  endtask

  // Monitor: one comparison per cycle whenever the scoreboard holds an entry.
  always @(negedge clk) begin
    sb_t e;
    logic [13:0] ex, ob;
    cyc_no++;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      ex = {e.c.stg, e.c.ir, e.c.pc, e.c.rf, e.c.we, e.c.re,
            (e.c.stg != 3'd0 && e.c.stg != 3'd6), (e.c.stg == 3'd6), e.ret};
      ob = {stage, ir_load, pc_en, rf_we, dmem_we, dmem_re, busy, halted, retired};
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL cycle%0d stg/ir/pc/rf/we/re/busy/halt/ret got=%b want=%b",
                 cyc_no, ob, ex);
      end
    end
  end

  initial begin
    int guard;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", {stage, ir_load, pc_en, rf_we, dmem_we, dmem_re, busy, halted, 4'(retired)},
        16'h0000);
    release_reset();

    // Directed ALU start in free run, then random free-run / step / run-drop mix.
    force_kind = 0;
    tick(1, 0, 0);
    force_kind = -1;
    repeat (60) tick(1, 0, 0);
    repeat (500) tick($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 3) == 0);
    // Drain to IDLE.
    guard = 0;
    while (pend.size() > 0 && guard < 50) begin tick(0, 0, 0); guard++; end
    tick(0, 0, 0);

    // Single-step: pulses at cycles 0, 2 (inside FETCH, dropped) and 20.
    for (int i = 0; i < 30; i++) tick(1, 1, (i == 0) || (i == 2) || (i == 20));

    // Reset during the first MEM cycle of a store.
    force_kind = 3;
    guard = 0;
    while (!(pend.size() > 0 && pend[0].we) && guard < 40) begin tick(1, 0, 0); guard++; end
    if (guard >= 40) chk("store_mem_timeout", 16'(guard), 16'd0);
    @(posedge clk); #1;
    void'(pend.pop_front());
    chk("store_dmem_we_on", 16'(dmem_we), 16'd1);
    reset = 1'b0; #1;
    chk("abort_dmem_we", 16'(dmem_we), 16'd0);
    chk("abort_stage", {13'd0, stage}, 16'd0);
    chk("abort_retired", 16'(retired), 16'd0);
    model_reset();
    release_reset();

    // Halt: becomes sticky, run toggling has no effect, async reset clears it.
    repeat (3) tick(1, 0, 0);
    force_kind = 7;
    guard = 0;
    while (!halted_m && guard < 40) begin tick(1, 0, 0); guard++; end
    if (guard >= 40) chk("halt_timeout", 16'(guard), 16'd0);
    for (int i = 0; i < 12; i++) tick(i[0], $urandom_range(0, 1) == 1, 1);
    @(posedge clk); #3;
    reset = 1'b0; #1;
    chk("halt_reset_stage", {13'd0, stage}, 16'd0);
    chk("halt_reset_halted", 16'(halted), 16'd0);
    model_reset();
    release_reset();
    repeat (5) tick(0, 0, 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/g9_stage_sequencer.md
# g9_stage_sequencer

Multi-cycle stage sequencer for the G9 processor. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK and generates the one-cycle enables that advance the program counter, load the instruction register, write the register file and write data memory. It replaces free-running per-clock PC/RF/DMem updates, so that block-RAM read latency is respected and execution can be run, single-stepped or halted.

## Interface

Parameters:
- IMEM_LATENCY, 1, instruction-memory read latency in cycles; legal 1..7.
- DMEM_LATENCY, 1, data-memory read latency in cycles; legal 1..7.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- run  in  1  level; 1 permits instruction issue.
- step_mode  in  1  level; 1 requires a step pulse per instruction.
- step  in  1  single-step request; sampled only in IDLE.
- mem_read  in  1  from control unit; instruction is a load.
- mem_write  in  1  from control unit; instruction is a store.
- reg_write  in  1  from control unit; instruction writes rd.
- halt  in  1  from control unit; instruction is HALT.
- ir_load  out  1  latch the instruction register (last FETCH cycle).
- pc_en  out  1  load pc_next into the PC (retire cycle).
- rf_we  out  1  register-file write strobe.
- dmem_we  out  1  data-memory write strobe.
- dmem_re  out  1  data-memory read enable.
- busy  out  1  1 when the state is neither IDLE nor HALT.
- halted  out  1  1 in HALT.
- stage  out  3  current state encoding.
- retired  out  CNT_WIDTH  count of retired instructions.

## Operation

- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encodings 7 and above are unreachable and return to IDLE on the next clock.
- IDLE: go to FETCH if run && (!step_mode || step). Otherwise stay.
- FETCH: stay IMEM_LATENCY cycles (internal wait counter). ir_load=1 on the final FETCH cycle only. Then go to DECODE.
- DECODE: one cycle. mem_read, mem_write, reg_write and halt are sampled and latched at the end of this cycle. Inputs are ignored in every other state.
  - If halt is latched, go to HALT.
  - Otherwise go to EXEC.
- EXEC: one cycle.
  - If the latched mem_read or mem_write is set, go to MEM.
  - Else if reg_write is set, go to WB.
  - Else retire.
- MEM: stay DMEM_LATENCY cycles.
  - dmem_re=1 on every MEM cycle when mem_read is set.
  - dmem_we=1 on the first MEM cycle only when mem_write is set.
  - mem_read and mem_write both set: mem_read wins and dmem_we stays 0.
  - After MEM: a load goes to WB; otherwise retire.
- WB: rf_we=1 for one cycle, then retire.
- Retire: pc_en=1 in the final cycle of the instruction (EXEC, the last MEM cycle, or WB). retired increments by 1 in that same cycle and wraps modulo 2^CNT_WIDTH. The next state is FETCH if run && !step_mode, else IDLE.
- HALT: sticky until reset. pc_en, rf_we, dmem_we and dmem_re are 0. retired is not incremented for HALT.
- run falling mid-instruction: the instruction completes and retires, then the sequencer enters IDLE.
- step_mode changing mid-instruction: takes effect at the next retire.
- All strobes (ir_load, pc_en, rf_we, dmem_we, dmem_re) are decoded from registered state, the wait counter and the latched flags only. They are glitch-free and never depend combinationally on the inputs.

## Timing

- Reset values: state IDLE, every strobe 0, busy 0, halted 0, stage 0, retired 0, wait counter 0, latched flags 0.
- Reset asserted mid-instruction aborts immediately. No partial strobe occurs after reset is asserted.
- First FETCH cycle is the clock after IDLE sees the issue condition.
- Instruction length with IMEM_LATENCY=L and DMEM_LATENCY=D:
  - ALU: L+3 cycles.
  - Load: L+D+3 cycles.
  - Store: L+D+2 cycles.
  - Branch or no-write instruction: L+2 cycles.
- Back-to-back issue in free-run mode: FETCH follows the retire cycle directly, with no IDLE bubble.
- Single-step: one step pulse in IDLE gives exactly one instruction. Pulses outside IDLE are dropped.

## Test plan

- Reset release, run=1, step_mode=0, L=D=1, ALU instruction (reg_write=1): stage sequence 1,2,3,5. rf_we and pc_en both high in cycle 4. retired=1. FETCH again in cycle 5.
- Load with L=2, D=3: FETCH 2 cycles, DECODE, EXEC, MEM 3 cycles with dmem_re high throughout, then WB with rf_we. pc_en only in the WB cycle. Total 8 cycles.
- Store with mem_read=mem_write=0 first, then mem_write=1, D=2: dmem_we high exactly one cycle (the first MEM cycle). rf_we never high. pc_en in the second MEM cycle.
- step_mode=1 with three step pulses, one of them during FETCH: exactly 2 instructions retire. retired=2. busy is 0 between instructions.
- halt=1 at DECODE: state reaches 6 and halted=1 thereafter. run toggling has no effect. retired is unchanged. Reset low returns state 0 asynchronously, before the next clock edge.
- CNT_WIDTH=4, free run of 17 ALU instructions: retired reads 1 after wrapping. reset asserted during MEM of a store: dmem_we drops to 0 immediately.
